// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for a subtractive GCD datapath.
//   clk        - rising-edge clock
//   rst        - synchronous, active-low reset
//   start      - begin a run on the datapath's current in1/in2 operands
//   a_gt_b, a_lt_b, a_eq_b - comparator flags from the A/B registers
//   a_ld, b_ld - A/B register load enables (decoded from state and flags)
//   a_sel, b_sel - A/B mux selects (0 = external operand, 1 = subtractor)
//   output_en  - load enable for the result register (captures B)
//   busy       - high from the accepted start until the return to IDLE
//   done       - one-cycle pulse while the result register is valid
//   err        - sticky error flag (flag conflict or iteration timeout)
//   iter_count - subtractions performed in the current or last run
module gcd_controller #(
  parameter int unsigned ITER_W   = 16,
  parameter int unsigned MAX_ITER = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_gt_b,
  input  logic              a_lt_b,
  input  logic              a_eq_b,
  output logic              a_ld,
  output logic              b_ld,
  output logic              a_sel,
  output logic              b_sel,
  output logic              output_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned FLAG_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              iter_clr;
  logic              iter_inc;
  logic [FLAG_W-1:0] flags;
  logic              flags_one_hot;
  logic              at_limit;

  assign flags         = {a_gt_b, a_lt_b, a_eq_b};
  assign flags_one_hot = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
  assign at_limit      = (iter_count == ITER_W'(MAX_ITER));

  // State, status flags and iteration counter; status flags follow next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      iter_count <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n == S_LOAD) || (state_n == S_CALC) || (state_n == S_DONE);
      done  <= (state_n == S_DONE);
      err   <= (state_n == S_ERR);
      if (iter_clr) begin
        iter_count <= '0;
      end else if (iter_inc && (iter_count != {ITER_W{1'b1}})) begin
        iter_count <= iter_count + ITER_W'(1);
      end
    end
  end

  // Next state and datapath enables
  always_comb begin
    state_n   = state;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    output_en = 1'b0;
    iter_clr  = 1'b0;
    iter_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_LOAD;
      end
      S_LOAD: begin
        a_ld     = 1'b1;
        b_ld     = 1'b1;
        iter_clr = 1'b1;
        state_n  = S_CALC;
      end
      S_CALC: begin
        if (!flags_one_hot) begin
          state_n = S_ERR;
        end else if (a_eq_b) begin
          output_en = 1'b1;
          state_n   = S_DONE;
        end else if (at_limit) begin
          // Subtraction needed but budget exhausted: abort without loading
          state_n = S_ERR;
        end else if (a_gt_b) begin
          a_ld     = 1'b1;
          a_sel    = 1'b1;
          iter_inc = 1'b1;
        end else begin
          b_ld     = 1'b1;
          b_sel    = 1'b1;
          iter_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_ERR: begin
        if (start) state_n = S_LOAD;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Testbench for gcd_controller. Two instances share clk/rst: dut (default
// MAX_ITER) for the main runs and dut_t (MAX_ITER=10) for the timeout case.
// Each has a small A/B/result datapath model feeding the comparator flags.
module tb_gcd_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start;
  logic [1:0]  gt, lt, eq;
  logic [1:0]  a_ld, b_ld, a_sel, b_sel, oe, busy, done, err;
  logic [15:0] ic [2];
  logic [15:0] in1 [2];
  logic [15:0] in2 [2];
  logic [15:0] ra [2];
  logic [15:0] rb [2];
  logic [15:0] res [2];
  logic        force_bad;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic [15:0] n;
    logic        is_err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  gcd_controller dut (
    .clk(clk), .rst(rst), .start(start[0]),
    .a_gt_b(gt[0]), .a_lt_b(lt[0]), .a_eq_b(eq[0]),
    .a_ld(a_ld[0]), .b_ld(b_ld[0]), .a_sel(a_sel[0]), .b_sel(b_sel[0]),
    .output_en(oe[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .iter_count(ic[0])
  );

  gcd_controller #(.ITER_W(16), .MAX_ITER(10)) dut_t (
    .clk(clk), .rst(rst), .start(start[1]),
    .a_gt_b(gt[1]), .a_lt_b(lt[1]), .a_eq_b(eq[1]),
    .a_ld(a_ld[1]), .b_ld(b_ld[1]), .a_sel(a_sel[1]), .b_sel(b_sel[1]),
    .output_en(oe[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .iter_count(ic[1])
  );

  // Comparator flags; force_bad makes instance 0 see conflicting flags
  assign gt[0] = force_bad | (ra[0] > rb[0]);
  assign lt[0] = force_bad | (ra[0] < rb[0]);
  assign eq[0] = !force_bad && (ra[0] == rb[0]);
  assign gt[1] = ra[1] > rb[1];
  assign lt[1] = ra[1] < rb[1];
  assign eq[1] = ra[1] == rb[1];

  // Datapath registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_ld[i]) ra[i] <= a_sel[i] ? ra[i] - rb[i] : in1[i];
      if (b_ld[i]) rb[i] <= b_sel[i] ? rb[i] - ra[i] : in2[i];
      if (oe[i])   res[i] <= rb[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for instance 0, plus enable-encoding guards on both
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (done[0]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", 32'(res[0]), 32'(e.res));
          check("iter_count_done", 32'(ic[0]), 32'(e.n));
          check("done_on_err_run", 32'(e.is_err), 32'd0);
          check("err_low_at_done", 32'(err[0]), 32'd0);
        end
      end
      if (err[0] && !err_prev) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_err", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("err_on_ok_run", 32'(e.is_err), 32'd1);
          check("iter_count_err", 32'(ic[0]), 32'(e.n));
        end
      end
    end
    err_prev = err[0];
    for (int i = 0; i < 2; i++) begin
      if (a_sel[i] || b_sel[i]) begin
        check("a_sel_without_a_ld", 32'(a_sel[i] && !a_ld[i]), 32'd0);
        check("b_sel_without_b_ld", 32'(b_sel[i] && !b_ld[i]), 32'd0);
        check("calc_loads_one_hot", 32'(a_ld[i] && b_ld[i]), 32'd0);
      end
    end
  end

  function automatic logic [31:0] outs0();
    return {15'd0, ic[0], a_ld[0], b_ld[0], a_sel[0], b_sel[0],
            oe[0], busy[0], done[0], err[0]};
  endfunction

  // Full run on instance 0: pushes the expected result, checks latency
  task automatic run0(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_res, input int n, input bit inject);
    exp_t e;
    int   k;
    bit   got;
    in1[0] = a;
    in2[0] = b;
    e.res = exp_res;
    e.n = 16'(n);
    e.is_err = 1'b0;
    sb.push_back(e);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    check("busy_after_start", 32'(busy[0]), 32'd1);
    check("err_clear_after_start", 32'(err[0]), 32'd0);
    k = 0;
    got = 1'b0;
    while (!got && k < 2000) begin
      // Extra starts while busy must be ignored and not queued
      start[0] = inject && (k <= 1 + n) && (k % 2 == 1);
      @(posedge clk);
      k++;
      @(negedge clk);
      if (done[0]) got = 1'b1;
    end
    start[0] = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("done_latency", 32'(k), 32'(2 + n));
    @(negedge clk);
    check("done_one_cycle", 32'(done[0]), 32'd0);
    @(negedge clk);
    check("idle_after_done", 32'(busy[0]), 32'd0);
  endtask

  initial begin
    int pulses;
    int k;
    exp_t e;
    start = 2'b00;
    force_bad = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in1[i] = '0;
      in2[i] = '0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs_0", outs0(), 32'd0);
    check("reset_outputs_1", {15'd0, ic[1], a_ld[1], b_ld[1], a_sel[1], b_sel[1],
                              oe[1], busy[1], done[1], err[1]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run0(16'd12, 16'd8, 16'd4, 2, 1'b0);
    run0(16'd7, 16'd7, 16'd7, 0, 1'b0);
    run0(16'd0, 16'd0, 16'd0, 0, 1'b0);
    run0(16'd1071, 16'd462, 16'd21, 11, 1'b1);

    // Conflicting flags in CALC: ERR on the next edge, no loads
    e.res = '0;
    e.n = '0;
    e.is_err = 1'b1;
    sb.push_back(e);
    in1[0] = 16'd9;
    in2[0] = 16'd3;
    force_bad = 1'b1;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    check("bad_load_cycle", 32'({a_ld[0], b_ld[0], a_sel[0], b_sel[0]}), 32'b1100);
    @(negedge clk);
    check("bad_calc_no_enables", 32'({a_ld[0], b_ld[0], oe[0]}), 32'd0);
    @(negedge clk);
    check("bad_err_set", 32'(err[0]), 32'd1);
    check("bad_busy_clear", 32'(busy[0]), 32'd0);
    force_bad = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(err[0]), 32'd1);
    run0(16'd12, 16'd8, 16'd4, 2, 1'b0);

    // Timeout on instance 1 (MAX_ITER=10)
    in1[1] = 16'd5;
    in2[1] = 16'd0;
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    pulses = 0;
    k = 0;
    while (!err[1] && k < 100) begin
      if (a_ld[1] && a_sel[1]) pulses++;
      @(negedge clk);
      k++;
    end
    check("timeout_reached", 32'(err[1]), 32'd1);
    check("timeout_a_ld_pulses", 32'(pulses), 32'd10);
    check("timeout_busy", 32'(busy[1]), 32'd0);
    check("timeout_iter", 32'(ic[1]), 32'd10);
    check("timeout_no_loads", 32'({a_ld[1], b_ld[1]}), 32'd0);
    in1[1] = 16'd6;
    in2[1] = 16'd4;
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    check("rerun_err_cleared", 32'(err[1]), 32'd0);
    check("rerun_busy", 32'(busy[1]), 32'd1);
    k = 0;
    while (!done[1] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rerun_done", 32'(done[1]), 32'd1);
    check("rerun_result", 32'(res[1]), 32'd2);
    check("rerun_iter", 32'(ic[1]), 32'd2);

    // Reset mid-CALC of a 48/18 run
    in1[0] = 16'd48;
    in2[0] = 16'd18;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_reset_outputs", outs0(), 32'd0);
    start[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("start_ignored_in_reset", outs0(), 32'd0);
    start[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    run0(16'd48, 16'd18, 16'd6, 4, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 SHALL have parameter ITER_W, default 16: width of the iteration counter.
REQ-002 SHALL have parameter MAX_ITER, default 1000: maximum number of subtractions allowed before timeout.
REQ-003 SHALL have port clk  input  1: single clock, all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1: request to begin a GCD computation on the current in1/in2 datapath operands.
REQ-006 SHALL have ports a_gt_b, a_lt_b, a_eq_b  input  1 each: datapath comparator flags for registers A and B.
REQ-007 SHALL have ports a_ld, b_ld  output  1 each: datapath A/B register load enables.
REQ-008 SHALL have ports a_sel, b_sel  output  1 each: datapath mux selects (0 = external operand in1/in2, 1 = subtractor result).
REQ-009 SHALL have port output_en  output  1: load enable for the datapath result register, which captures B.
REQ-010 SHALL have port busy  output  1: high from the accepted start until return to IDLE.
REQ-011 SHALL have port done  output  1: one-cycle pulse; the result register is valid while done is high.
REQ-012 SHALL have port err  output  1: sticky error flag.
REQ-013 SHALL have port iter_count  output  ITER_W: number of subtractions performed in the current or last run.

Function
REQ-014 SHALL implement a Moore/Mealy FSM with states IDLE, LOAD, CALC, DONE and ERR; all outputs are registered or decoded from state and flags only.
REQ-015 IDLE: all enables 0. A start sampled high at edge E0 goes to LOAD, and busy=1 and err=0 take effect after E0.
REQ-016 LOAD: a_ld=b_ld=1 and a_sel=b_sel=0 for exactly one cycle; iter_count is cleared to 0 at the next edge; next state is CALC.
REQ-017 CALC with exactly one flag high:
  - a_gt_b: a_ld=1, a_sel=1, iter_count+1, stay in CALC.
  - a_lt_b: b_ld=1, b_sel=1, iter_count+1, stay in CALC.
  - a_eq_b: output_en=1, next state DONE.
REQ-018 CALC: at most one of a_ld/b_ld SHALL be high in any cycle; a_sel/b_sel SHALL be 0 whenever the matching load enable is 0.
REQ-019 CALC: if a subtraction is required and iter_count == MAX_ITER, SHALL NOT assert a_ld/b_ld and SHALL go to ERR.
REQ-020 CALC: if zero or more than one flag is high, SHALL go to ERR with no enables asserted.
REQ-021 DONE: done=1 for one cycle, busy=1, then IDLE; iter_count SHALL hold its final value until the next LOAD.
REQ-022 ERR: err=1 and busy=0; all enables 0; SHALL stay in ERR until start (goes to LOAD and clears err) or reset.
REQ-023 start while busy (LOAD, CALC, DONE) SHALL be ignored and not queued.
REQ-024 Latency: with N subtractions and start sampled at E0, output_en is high in the cycle before E(2+N), and done is high for the cycle following E(2+N).
REQ-025 Operands (0,0) SHALL complete with N=0 and result 0. One zero operand with the other nonzero SHALL end in ERR via timeout.
REQ-026 iter_count SHALL saturate and never wrap; MAX_ITER SHALL be less than 2^ITER_W.

Reset
REQ-027 rst low at a rising edge SHALL force IDLE, and all outputs SHALL be 0 after that edge (a_ld, b_ld, a_sel, b_sel, output_en, busy, done, err, iter_count); this holds from any state, including mid-CALC.
REQ-028 While rst is low, start SHALL be ignored. The first start sampled after rst returns high SHALL begin a normal run.

Verification
REQ-029 in1=12, in2=8, start pulse at E0 -> LOAD; gt then lt; done high after E4; result=4; iter_count=2; err=0.
REQ-030 in1=in2=7 -> no subtraction; done high after E2; result=7; iter_count=0.
REQ-031 in1=5, in2=0 with MAX_ITER=10 -> 10 a_ld pulses, then err=1 and busy=0; a second start clears err and reruns.
REQ-032 in1=1071, in2=462 -> result 21; one-hot check on a_ld/b_ld held every cycle; start pulses injected mid-run have no effect.
REQ-033 rst driven low during CALC of a 48/18 run -> all outputs 0 after the edge; a new run with 48/18 gives result 6.
REQ-034 Force a_gt_b=a_lt_b=1 in CALC -> ERR next edge with no loads asserted.
